// File: rtl/t07_mmio_router.sv
// Routes one CPU request at a time to Wishbone, the external register block or the SPI TFT.
// Illegal or unmapped requests, and requests whose target never answers, complete with cpu_err.
module t07_mmio_router #(
  parameter int unsigned IMEM_LIMIT = 1024,
  parameter int unsigned REG_BASE   = 1025,
  parameter int unsigned REG_LIMIT  = 1056,
  parameter int unsigned DMEM_BASE  = 1057,
  parameter int unsigned DMEM_LIMIT = 1792,
  parameter int unsigned TFT_BASE   = 1793,
  parameter int unsigned TFT_LIMIT  = 2047,
  parameter logic [7:0]  EXT_PREFIX = 8'h33,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req_valid,
  input  logic [1:0]  req_rwi,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic [31:0] cpu_instr,
  output logic        cpu_err,
  output logic        wb_read,
  output logic        wb_write,
  output logic [31:0] wb_addr,
  output logic [31:0] wb_wdata,
  input  logic [31:0] wb_rdata,
  input  logic        wb_busy,
  output logic        reg_ri,
  output logic [4:0]  reg_addr,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ack,
  output logic        tft_wi,
  output logic [31:0] tft_addr,
  output logic [31:0] tft_wdata,
  input  logic        tft_ack
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;
  typedef enum logic [1:0] {TgtNone, TgtWb, TgtReg, TgtTft} tgt_e;

  state_e          state_q, state_d;
  tgt_e            tgt_q, tgt_d, dec_tgt;
  logic [1:0]      rwi_q, rwi_d;
  logic [31:0]     addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0]     data_q, data_d, instr_q, instr_d;
  logic            err_q, err_d, ack_q, ack_d, busy_seen_q, busy_seen_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tgt_ack, wb_done;

  always_comb begin
    dec_tgt = TgtNone;
    if (req_rwi == 2'b11 && req_addr <= IMEM_LIMIT) begin
      dec_tgt = TgtWb;
    end else if (req_rwi == 2'b10 && req_addr >= REG_BASE && req_addr <= REG_LIMIT) begin
      dec_tgt = TgtReg;
    end else if (req_rwi[1] != req_rwi[0] && req_addr >= DMEM_BASE && req_addr <= DMEM_LIMIT) begin
      dec_tgt = TgtWb;
    end else if (req_rwi == 2'b01 && req_addr >= TFT_BASE && req_addr <= TFT_LIMIT) begin
      dec_tgt = TgtTft;
    end
  end

  // Only the latched target's ack counts; the others are ignored.
  assign tgt_ack = (tgt_q == TgtReg && reg_ack) || (tgt_q == TgtTft && tft_ack);
  assign wb_done = (tgt_q == TgtWb) && busy_seen_q && !wb_busy;

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    rwi_d       = rwi_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    instr_d     = instr_q;
    err_d       = err_q;
    ack_d       = ack_q;
    busy_seen_d = busy_seen_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_rwi != 2'b00) begin
          rwi_d       = req_rwi;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          tgt_d       = dec_tgt;
          data_d      = '0;
          ack_d       = 1'b0;
          busy_seen_d = 1'b0;
          err_d       = (dec_tgt == TgtNone);
          state_d     = (dec_tgt == TgtNone) ? StDone : StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
        if (tgt_q == TgtWb && wb_busy) busy_seen_d = 1'b1;
        if (tgt_ack) begin
          ack_d = 1'b1;
          if (tgt_q == TgtReg) data_d = reg_rdata;
        end
      end
      StWait: begin
        if (ack_q || tgt_ack || wb_done) begin
          state_d = StDone;
          if (!ack_q && tgt_q == TgtReg) data_d = reg_rdata;
          if (wb_done) begin
            data_d = wb_rdata;
            if (rwi_q == 2'b11) instr_d = wb_rdata;
          end
        end else if (cnt_q == CntLast) begin
          state_d = StDone;
          err_d   = 1'b1;
          data_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (tgt_q == TgtWb && wb_busy) busy_seen_d = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= StIdle;
      tgt_q       <= TgtNone;
      rwi_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      data_q      <= '0;
      instr_q     <= '0;
      err_q       <= 1'b0;
      ack_q       <= 1'b0;
      busy_seen_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      rwi_q       <= rwi_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      instr_q     <= instr_d;
      err_q       <= err_d;
      ack_q       <= ack_d;
      busy_seen_q <= busy_seen_d;
      cnt_q       <= cnt_d;
    end
  end

  // All outputs decode from registered state so reset clears them immediately.
  assign cpu_busy  = (state_q == StIssue) || (state_q == StWait);
  assign cpu_done  = (state_q == StDone);
  assign cpu_err   = (state_q == StDone) && err_q;
  assign cpu_rdata = (state_q == StDone && !err_q && rwi_q == 2'b10) ? data_q : '0;
  assign cpu_instr = instr_q;

  assign wb_read   = (state_q == StIssue) && (tgt_q == TgtWb) && rwi_q[1];
  assign wb_write  = (state_q == StIssue) && (tgt_q == TgtWb) && (rwi_q == 2'b01);
  assign wb_addr   = (cpu_busy && tgt_q == TgtWb) ? {EXT_PREFIX, addr_q[23:0]} : '0;
  assign wb_wdata  = (cpu_busy && tgt_q == TgtWb) ? wdata_q : '0;

  assign reg_ri    = (tgt_q == TgtReg) &&
                     ((state_q == StIssue) || (state_q == StWait && !ack_q));
  assign reg_addr  = reg_ri ? addr_q[4:0] : '0;

  assign tft_wi    = (tgt_q == TgtTft) &&
                     ((state_q == StIssue) || (state_q == StWait && !ack_q));
  assign tft_addr  = tft_wi ? addr_q : '0;
  assign tft_wdata = tft_wi ? wdata_q : '0;

endmodule

// File: tb/tb_t07_mmio_router.sv
// Bench for t07_mmio_router: directed corner cases plus random requests, each checked against
// a transaction-level model of target selection, latency, strobe counts and returned data.
module tb_t07_mmio_router;

  localparam int unsigned TO = 8;
  localparam int TgNone = 0, TgWb = 1, TgReg = 2, TgTft = 3;

  logic        clk = 1'b0;
  logic        nrst;
  logic        req_valid;
  logic [1:0]  req_rwi;
  logic [31:0] req_addr, req_wdata;
  logic        cpu_busy, cpu_done, cpu_err;
  logic [31:0] cpu_rdata, cpu_instr;
  logic        wb_read, wb_write, wb_busy;
  logic [31:0] wb_addr, wb_wdata, wb_rdata;
  logic        reg_ri, reg_ack;
  logic [4:0]  reg_addr;
  logic [31:0] reg_rdata;
  logic        tft_wi, tft_ack;
  logic [31:0] tft_addr, tft_wdata;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_instr = '0;

  always #5 clk = ~clk;

  t07_mmio_router #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .req_valid (req_valid),
    .req_rwi   (req_rwi),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .cpu_busy  (cpu_busy),
    .cpu_done  (cpu_done),
    .cpu_rdata (cpu_rdata),
    .cpu_instr (cpu_instr),
    .cpu_err   (cpu_err),
    .wb_read   (wb_read),
    .wb_write  (wb_write),
    .wb_addr   (wb_addr),
    .wb_wdata  (wb_wdata),
    .wb_rdata  (wb_rdata),
    .wb_busy   (wb_busy),
    .reg_ri    (reg_ri),
    .reg_addr  (reg_addr),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack),
    .tft_wi    (tft_wi),
    .tft_addr  (tft_addr),
    .tft_wdata (tft_wdata),
    .tft_ack   (tft_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "/ctl"}, 32'({cpu_busy, cpu_done, cpu_err, wb_read, wb_write, reg_ri, tft_wi,
                            reg_addr}), 32'd0);
    chk({tag, "/cpu_rdata"}, cpu_rdata, 32'd0);
    chk({tag, "/cpu_instr"}, cpu_instr, 32'd0);
    chk({tag, "/buses"}, wb_addr | wb_wdata | tft_addr | tft_wdata, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Address map as the CPU sees it.
  function automatic int target_of(input logic [1:0] rwi, input logic [31:0] a);
    if (rwi == 2'b11 && a <= 32'd1024) return TgWb;
    if (rwi == 2'b10 && a >= 32'd1025 && a <= 32'd1056) return TgReg;
    if ((rwi == 2'b10 || rwi == 2'b01) && a >= 32'd1057 && a <= 32'd1792) return TgWb;
    if (rwi == 2'b01 && a >= 32'd1793 && a <= 32'd2047) return TgTft;
    return TgNone;
  endfunction

  // resp: WB = cycles wb_busy stays high (0 = never), REG/TFT = cycle index of the ack
  // (0 = during ISSUE). Latency counts cycles after the acceptance edge up to cpu_done.
  task automatic run_txn(input string tag, input logic [1:0] rwi, input logic [31:0] addr,
                         input logic [31:0] wdata, input int resp, input logic [31:0] rdata);
    int tgt, exp_lat, exp_strobe, done_at, nrd, nwr, nreg, ntft, nbusy, bad;
    logic exp_err, obs_err;
    logic [31:0] exp_rdata, obs_rdata, obs_instr;
    tgt = target_of(rwi, addr);
    exp_err = 1'b0;
    exp_strobe = 0;
    if (tgt == TgNone) begin
      exp_lat = 1;
      exp_err = 1'b1;
    end else if (tgt == TgWb) begin
      if (resp >= 1 && resp + 1 <= int'(TO)) exp_lat = resp + 3;
      else begin
        exp_lat = TO + 2;
        exp_err = 1'b1;
      end
    end else if (resp <= int'(TO)) begin
      exp_lat = (resp == 0) ? 3 : resp + 2;
      exp_strobe = resp + 1;
    end else begin
      exp_lat = TO + 2;
      exp_strobe = TO + 1;
      exp_err = 1'b1;
    end
    exp_rdata = (rwi == 2'b10 && !exp_err) ? rdata : 32'd0;
    if (rwi == 2'b11 && tgt == TgWb && !exp_err) exp_instr = rdata;

    req_valid = 1'b1;
    req_rwi   = rwi;
    req_addr  = addr;
    req_wdata = wdata;
    if (cpu_done === 1'b1) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "/done_one_shot"}, 32'(cpu_done), 32'd0);
    end

    done_at = 0; nrd = 0; nwr = 0; nreg = 0; ntft = 0; nbusy = 0; bad = 0;
    obs_err = 1'bx; obs_rdata = 'x; obs_instr = 'x;
    for (int c = 1; c <= 30 && done_at == 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (wb_read) nrd++;
      if (wb_write) nwr++;
      if (reg_ri) nreg++;
      if (tft_wi) ntft++;
      if (cpu_busy) nbusy++;
      if ((wb_read || wb_write || (cpu_busy && tgt == TgWb)) &&
          (wb_addr !== {8'h33, addr[23:0]} || wb_wdata !== wdata)) bad++;
      if (reg_ri && reg_addr !== addr[4:0]) bad++;
      if (tft_wi && (tft_addr !== addr || tft_wdata !== wdata)) bad++;
      if (cpu_done) begin
        done_at   = c;
        obs_err   = cpu_err;
        obs_rdata = cpu_rdata;
        obs_instr = cpu_instr;
        req_valid = 1'b0;
        wb_busy   = 1'b0;
        reg_ack   = 1'b0;
        tft_ack   = 1'b0;
      end else begin
        wb_busy   = (tgt == TgWb) ? (c >= 2 && c <= resp + 1) : 1'($urandom_range(0, 1));
        wb_rdata  = (tgt == TgWb && c == resp + 2) ? rdata : $urandom;
        reg_ack   = (tgt == TgReg) ? (reg_ri && c >= resp + 1) : 1'($urandom_range(0, 1));
        tft_ack   = (tgt == TgTft) ? (tft_wi && c >= resp + 1) : 1'($urandom_range(0, 1));
        reg_rdata = (tgt == TgReg && reg_ack) ? rdata : $urandom;
      end
    end

    chk({tag, "/latency"}, 32'(done_at), 32'(exp_lat));
    chk({tag, "/cpu_err"}, 32'(obs_err), 32'(exp_err));
    chk({tag, "/cpu_rdata"}, obs_rdata, exp_rdata);
    chk({tag, "/cpu_instr"}, obs_instr, exp_instr);
    chk({tag, "/wb_read_pulses"}, 32'(nrd), 32'((tgt == TgWb && rwi[1]) ? 1 : 0));
    chk({tag, "/wb_write_pulses"}, 32'(nwr), 32'((tgt == TgWb && rwi == 2'b01) ? 1 : 0));
    chk({tag, "/reg_ri_cycles"}, 32'(nreg), 32'((tgt == TgReg) ? exp_strobe : 0));
    chk({tag, "/tft_wi_cycles"}, 32'(ntft), 32'((tgt == TgTft) ? exp_strobe : 0));
    chk({tag, "/busy_cycles"}, 32'(nbusy), 32'((tgt == TgNone) ? 0 : exp_lat - 1));
    chk({tag, "/addr_data"}, 32'(bad), 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    int n;
    nrst = 1'b0; req_valid = 1'b0; req_rwi = '0; req_addr = '0; req_wdata = '0;
    wb_rdata = '0; wb_busy = 1'b0; reg_rdata = '0; reg_ack = 1'b0; tft_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    nrst = 1'b1;
    idle(1);

    // rwi=00 is never accepted
    req_valid = 1'b1;
    n = 0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (cpu_busy || cpu_done) n++;
    end
    chk("idle_rwi00", 32'(n), 32'd0);
    req_valid = 1'b0;

    run_txn("fetch_0x100", 2'b11, 32'h100, 32'h0, 4, 32'h00A00093);
    run_txn("reg_rd_1030", 2'b10, 32'd1030, 32'h0, 2, 32'hDEADBEEF);
    run_txn("tft_wr_1800", 2'b01, 32'd1800, 32'h1234, 1, 32'h0);
    run_txn("ill_wr_reg", 2'b01, 32'd1030, 32'h55, 1, 32'h0);
    run_txn("ill_rd_tft", 2'b10, 32'd1800, 32'h0, 1, 32'h1111);
    run_txn("ill_fetch_1100", 2'b11, 32'd1100, 32'h0, 1, 32'h2222);
    run_txn("unmapped_3000", 2'b10, 32'd3000, 32'h0, 1, 32'h3333);
    run_txn("timeout_dmem", 2'b10, 32'd1500, 32'h0, 0, 32'hCAFEF00D);
    run_txn("reg_ack_issue", 2'b10, 32'd1056, 32'h0, 0, 32'h5A5A0001);
    run_txn("reg_ack_last", 2'b10, 32'd1025, 32'h0, 8, 32'h0BADF00D);
    run_txn("reg_timeout", 2'b10, 32'd1040, 32'h0, 9, 32'h12345678);
    run_txn("tft_timeout", 2'b01, 32'd2047, 32'h9, 12, 32'h0);
    run_txn("tft_base", 2'b01, 32'd1793, 32'hABCD, 0, 32'h0);
    run_txn("wb_last", 2'b10, 32'd1057, 32'h0, 7, 32'h600DCAFE);
    run_txn("wb_timeout_wr", 2'b01, 32'd1792, 32'h77, 8, 32'h0);
    run_txn("dmem_wr", 2'b01, 32'd1200, 32'hFEED, 2, 32'h0);
    run_txn("fetch_limit", 2'b11, 32'd1024, 32'h0, 1, 32'h00000013);
    run_txn("fetch_1025", 2'b11, 32'd1025, 32'h0, 1, 32'h44);
    run_txn("wr_2048", 2'b01, 32'd2048, 32'h1, 1, 32'h0);
    run_txn("fetch_hi_bits", 2'b11, 32'h3300_0100, 32'h0, 1, 32'h66);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       ra = $urandom_range(0, 1024);
        1:       ra = $urandom_range(1025, 1056);
        2:       ra = $urandom_range(1057, 1792);
        3:       ra = $urandom_range(1793, 2047);
        4:       ra = $urandom_range(2048, 4095);
        default: ra = $urandom;
      endcase
      run_txn("rand", 2'($urandom_range(1, 3)), ra, $urandom, int'($urandom_range(0, 10)),
              $urandom);
    end

    run_txn("fetch_pre_reset", 2'b11, 32'h40, 32'h0, 2, 32'h00500113);
    idle(1);

    // Reset in the middle of a Wishbone wait
    req_valid = 1'b1; req_rwi = 2'b11; req_addr = 32'h200; req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    wb_busy = 1'b1;
    idle(2);
    chk("midwait_busy", 32'(cpu_busy), 32'd1);
    nrst = 1'b0;
    #1;
    exp_instr = '0;
    chk_all_zero("midwait_reset");
    req_valid = 1'b0;
    wb_busy = 1'b0;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_done) n++;
    end
    chk("midwait_no_done", 32'(n), 32'd0);
    nrst = 1'b1;
    run_txn("fetch_after_reset", 2'b11, 32'h80, 32'h0, 3, 32'h00100073);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/t07_mmio_router.md
T07_MMIO_ROUTER -- requirements
Module: t07_mmio_router

Interface
Parameters:
REQ-001 SHALL have parameter IMEM_LIMIT, default 1024, meaning highest fetch address.
REQ-002 SHALL have parameter REG_BASE, default 1025, and REG_LIMIT, default 1056, meaning the external-register window (inclusive).
REQ-003 SHALL have parameter DMEM_BASE, default 1057, and DMEM_LIMIT, default 1792, meaning the data-memory window (inclusive).
REQ-004 SHALL have parameter TFT_BASE, default 1793, and TFT_LIMIT, default 2047, meaning the SPI TFT window (inclusive).
REQ-005 SHALL have parameter EXT_PREFIX, default 8'h33, meaning bits [31:24] of every Wishbone address.
REQ-006 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of WAIT cycles before an error completion.

Ports:
REQ-007 SHALL have ports: clk in 1, system clock; nrst in 1, reset.
REQ-008 SHALL have CPU-side ports: req_valid in 1; req_rwi in 2 (01 write, 10 read, 11 fetch, 00 idle); req_addr in 32; req_wdata in 32; cpu_busy out 1; cpu_done out 1; cpu_rdata out 32; cpu_instr out 32; cpu_err out 1.
REQ-009 SHALL have Wishbone-manager ports: wb_read out 1; wb_write out 1; wb_addr out 32; wb_wdata out 32; wb_rdata in 32; wb_busy in 1.
REQ-010 SHALL have register ports: reg_ri out 1; reg_addr out 5; reg_rdata in 32; reg_ack in 1.
REQ-011 SHALL have TFT ports: tft_wi out 1; tft_addr out 32; tft_wdata out 32; tft_ack in 1.
REQ-012 SHALL use one clock, clk; reset nrst SHALL be asynchronous and active-low.

Function
REQ-013 SHALL implement the FSM states IDLE, ISSUE, WAIT and DONE.
REQ-014 In IDLE, req_valid=1 with req_rwi!=00 SHALL be accepted; acceptance SHALL latch rwi, addr and wdata and decode the target.
REQ-015 Legal combinations SHALL be: fetch with addr<=IMEM_LIMIT to WB; read in the REG window to REG; read or write in the DMEM window to WB; write in the TFT window to TFT.
REQ-016 Any other combination SHALL go IDLE->DONE with cpu_err=1 and cpu_rdata=0, and SHALL issue no target strobe.
REQ-017 A legal request SHALL go IDLE->ISSUE->WAIT.
REQ-018 For WB targets, wb_read (read or fetch) or wb_write SHALL pulse for exactly one cycle in ISSUE.
REQ-019 wb_addr SHALL equal {EXT_PREFIX, addr[23:0]}, and wb_wdata SHALL equal the latched wdata; both SHALL be held from ISSUE through WAIT.
REQ-020 A WB completion SHALL occur in WAIT when wb_busy has been sampled 1 at least once and is then sampled 0; wb_rdata SHALL be captured on that cycle.
REQ-021 For REG, reg_ri SHALL be held at 1 and reg_addr SHALL be held at addr[4:0] from ISSUE until reg_ack=1; reg_rdata SHALL be captured on the ack cycle.
REQ-022 For TFT, tft_wi SHALL be held at 1, with tft_addr=addr and tft_wdata=wdata, from ISSUE until tft_ack=1.
REQ-023 An ack or completion condition SHALL go WAIT->DONE.
REQ-024 An ack present during ISSUE SHALL be registered, with the transition to DONE on the next cycle.
REQ-025 A timeout counter SHALL clear on entry to WAIT and increment each WAIT cycle; reaching TIMEOUT without completion SHALL go to DONE with cpu_err=1 and cpu_rdata=0, and SHALL drop all strobes.
REQ-026 In DONE, cpu_done SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-027 In DONE, cpu_rdata SHALL present the captured data for reads.
REQ-028 cpu_instr SHALL present the captured data for fetches, and SHALL be held until the next fetch completes.
REQ-029 Minimum latency SHALL be 3 cycles, from the acceptance edge to cpu_done (ISSUE, WAIT, DONE).
REQ-030 cpu_busy SHALL be 1 in ISSUE and WAIT, and 0 in IDLE and DONE.
REQ-031 req_valid SHALL be ignored outside IDLE; no queueing SHALL occur, and the CPU SHALL hold the request until cpu_done.
REQ-032 A request presented in the cycle DONE returns to IDLE SHALL be accepted on the following IDLE cycle.
REQ-033 Window tests SHALL be inclusive comparisons on the full 32-bit address; addresses above TFT_LIMIT SHALL be unmapped.
REQ-034 Simultaneous reg_ack and tft_ack SHALL be resolved by the latched target only; an ack from a non-selected target SHALL be ignored.

Reset
REQ-035 nrst=0 SHALL immediately force the state to IDLE, clear the timeout counter, clear the latches, and set every output to 0, including cpu_instr.
REQ-036 Reset mid-transaction SHALL abort without generating cpu_done; strobes SHALL drop asynchronously.
REQ-037 After nrst deasserts, the first acceptance SHALL occur on the first clk edge with req_valid=1.

Verification
REQ-038 Scenario fetch: rwi=11, addr=0x100, wb_busy high for 4 cycles then low, wb_rdata=0x00A00093 -> wb_read pulses once, wb_addr=0x33000100, cpu_done with cpu_instr=0x00A00093, cpu_err=0.
REQ-039 Scenario register read: rwi=10, addr=1030, reg_ack on the 2nd WAIT cycle, reg_rdata=0xDEADBEEF -> reg_addr=6, reg_ri held until ack, cpu_rdata=0xDEADBEEF.
REQ-040 Scenario TFT write: rwi=01, addr=1800, wdata=0x1234 -> tft_wi=1, tft_addr=1800, tft_wdata=0x1234 until ack; cpu_done follows, cpu_err=0.
REQ-041 Scenario illegal and unmapped requests: write to 1030, read to 1800, or fetch to 1100 -> no strobe, cpu_done 1 cycle after acceptance, cpu_err=1; addr=3000 gives the same response.
REQ-042 Scenario timeout: DMEM read with wb_busy stuck at 0, TIMEOUT=8 -> cpu_done with cpu_err=1 after 8 WAIT cycles, cpu_rdata=0.
REQ-043 Scenario reset mid-WAIT: nrst pulsed low during a WB transaction -> all outputs 0 at once, no cpu_done; a new fetch after release completes normally.
